ibex_register_file_ff_mp: RTL
=============================

// Module: ibex_register_file_ff_mp
//
// PURPOSE
//   Flip-flop register file, next generation: NUM_WORDS x DataWidth with
//   NumReadPorts combinational read ports and NumWritePorts write ports.
//   Adds optional same-cycle write-through and a sequential secure-wipe engine.
//   Sits between the decoder (reads) and writeback/LSU (writes) in the core.
//   Used for FPGA and Verilator targets.
//
// PARAMETERS
//   RV32E         0   1: NUM_WORDS=16 (addr bit 4 ignored for indexing), 0: NUM_WORDS=32
//   DataWidth     32  register width in bits
//   NumReadPorts  2   read ports, 1..4
//   NumWritePorts 2   write ports, 1..3; higher index = higher priority
//   WriteThrough  0   1: reads bypass same-cycle write data
//
// PORTS
//   clk_i           in   1                      clock, rising edge
//   rst_i           in   1                      async reset, active-high
//   raddr_i         in   5*NumReadPorts         read addresses, port p at [5p+:5]
//   rdata_o         out  DataWidth*NumReadPorts read data, port p at [DataWidth*p+:DataWidth]
//   waddr_i         in   5*NumWritePorts        write addresses
//   wdata_i         in   DataWidth*NumWritePorts write data
//   we_i            in   NumWritePorts          write enables
//   wipe_req_i      in   1                      start secure wipe (level-sampled)
//   wipe_busy_o     out  1                      wipe in progress
//   wipe_done_o     out  1                      1-cycle pulse at wipe completion
//   wr_collision_o  out  1                      1-cycle pulse: >=2 ports wrote same reg
//
// BEHAVIOUR
//   - Clock clk_i; reset rst_i asynchronous, active-high. Reset: all registers 0,
//     FSM IDLE, wipe counter 1, wipe_busy_o=0, wipe_done_o=0, wr_collision_o=0.
//   - R0: no storage; reads 0; writes to address 0 dropped. RV32E: address bit 4
//     is ignored for indexing (addresses alias modulo 16); writes to 16-31 alias 0-15.
//   - Write: a register updates at the clock edge from the highest-index port with
//     we_i set and a matching address; lower-index matches are dropped.
//   - wr_collision_o: registered; high in cycle N+1 iff in cycle N >=2 enabled
//     ports targeted the same nonzero register (after aliasing), outside WIPE.
//   - Read: combinational, zero latency. WriteThrough=0: pre-edge stored value.
//     WriteThrough=1: if any enabled write hits the read register (nonzero),
//     return the winning port's wdata, else the stored value.
//   - FSM IDLE -> WIPE when wipe_req_i=1 in IDLE. In WIPE: register[cnt] <= 0 at
//     each edge, cnt counts 1..NUM_WORDS-1; after cnt=NUM_WORDS-1 is cleared ->
//     DONE (one cycle, wipe_done_o=1) -> IDLE. Busy for NUM_WORDS-1 cycles
//     (31, or 15 for RV32E); done one cycle after.
//   - wipe_busy_o = (state==WIPE), registered from the FSM state.
//   - During WIPE and DONE: all we_i ignored, all rdata_o read 0, no collision
//     pulses. wipe_req_i in WIPE/DONE ignored; in IDLE after DONE starts a new wipe.
//   - Reset mid-wipe: aborts immediately; no wipe_done_o pulse.
//   - Counter wraps to 1 on leaving WIPE; no other overflow possible.
//
// TESTING
//   1. Reset; write 0xDEADBEEF to x5 via port 0; next cycle raddr p0=5 -> 0xDEADBEEF;
//      p1=0 -> 0.
//   2. Same cycle p0 writes x7=0x1111, p1 writes x7=0x2222 -> x7=0x2222 next cycle,
//      wr_collision_o=1 for exactly one cycle.
//   3. WriteThrough=1: write x3=0xA5A5 and read x3 same cycle -> rdata 0xA5A5;
//      WriteThrough=0 -> old value.
//   4. Fill x1..x31 with nonzero data, pulse wipe_req_i -> busy exactly 31 cycles,
//      then done pulse for 1 cycle, then all regs read 0; writes during busy lost.
//   5. RV32E=1: write x20=0x55 -> x4 reads 0x55; wipe busy for 15 cycles.
//   6. Assert rst_i at wipe cycle 10 -> busy drops at once, no done pulse, all regs 0.

Source files
------------

// File: rtl/ibex_register_file_ff_mp.sv
// Flip-flop register file with multiple read/write ports, optional same-cycle
// write-through and a sequential secure-wipe engine that clears one word per cycle.
module ibex_register_file_ff_mp #(
  parameter bit RV32E         = 1'b0,
  parameter int DataWidth     = 32,
  parameter int NumReadPorts  = 2,
  parameter int NumWritePorts = 2,
  parameter bit WriteThrough  = 1'b0
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [5*NumReadPorts-1:0]          raddr_i,
  output logic [DataWidth*NumReadPorts-1:0]  rdata_o,
  input  logic [5*NumWritePorts-1:0]         waddr_i,
  input  logic [DataWidth*NumWritePorts-1:0] wdata_i,
  input  logic [NumWritePorts-1:0]           we_i,
  input  logic                               wipe_req_i,
  output logic                               wipe_busy_o,
  output logic                               wipe_done_o,
  output logic                               wr_collision_o
);

  localparam int NumWords = RV32E ? 16 : 32;
  localparam int IdxW     = RV32E ? 4 : 5;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);

  typedef enum logic [1:0] {IDLE, WIPE, DONE} state_e;

  state_e               state;
  logic [IdxW-1:0]      wipe_cnt;
  logic [DataWidth-1:0] regs [1:NumWords-1];
  logic [IdxW-1:0]      widx [NumWritePorts];
  logic [DataWidth-1:0] wdat [NumWritePorts];
  logic                 collision;
  logic                 unused_addr_bits;

  // In RV32E mode address bit 4 plays no part in indexing.
  assign unused_addr_bits = ^{raddr_i, waddr_i};

  always_comb begin
    for (int p = 0; p < NumWritePorts; p++) begin
      widx[p] = waddr_i[5*p +: IdxW];
      wdat[p] = wdata_i[DataWidth*p +: DataWidth];
    end
  end

  always_comb begin
    collision = 1'b0;
    for (int i = 0; i < NumWritePorts; i++) begin
      for (int j = i + 1; j < NumWritePorts; j++) begin
        if (we_i[i] && we_i[j] && (widx[i] == widx[j]) && (widx[i] != '0)) begin
          collision = 1'b1;
        end
      end
    end
  end

  // Ascending port loop: the last (highest-index) matching write wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 1; r < NumWords; r++) begin
        regs[r] <= '0;
      end
    end else if (state == WIPE) begin
      regs[wipe_cnt] <= '0;
    end else if (state == IDLE) begin
      for (int p = 0; p < NumWritePorts; p++) begin
        if (we_i[p] && (widx[p] != '0)) begin
          regs[widx[p]] <= wdat[p];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      wipe_cnt       <= IdxW'(1);
      wipe_busy_o    <= 1'b0;
      wipe_done_o    <= 1'b0;
      wr_collision_o <= 1'b0;
    end else begin
      wr_collision_o <= (state == IDLE) && collision;
      case (state)
        IDLE: begin
          if (wipe_req_i) begin
            state       <= WIPE;
            wipe_busy_o <= 1'b1;
          end
        end
        WIPE: begin
          if (wipe_cnt == LastIdx) begin
            state       <= DONE;
            wipe_cnt    <= IdxW'(1);
            wipe_busy_o <= 1'b0;
            wipe_done_o <= 1'b1;
          end else begin
            wipe_cnt <= wipe_cnt + 1'b1;
          end
        end
        DONE: begin
          state       <= IDLE;
          wipe_done_o <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          wipe_busy_o <= 1'b0;
          wipe_done_o <= 1'b0;
        end
      endcase
    end
  end

  // Reads are masked to zero while a wipe is running or just finished.
  always_comb begin : read_mux
    logic [IdxW-1:0]      ridx;
    logic [DataWidth-1:0] rval;
    rdata_o = '0;
    ridx    = '0;
    rval    = '0;
    for (int p = 0; p < NumReadPorts; p++) begin
      ridx = raddr_i[5*p +: IdxW];
      rval = '0;
      if ((state == IDLE) && (ridx != '0)) begin
        rval = regs[ridx];
        if (WriteThrough) begin
          for (int w = 0; w < NumWritePorts; w++) begin
            if (we_i[w] && (widx[w] == ridx)) begin
              rval = wdat[w];
            end
          end
        end
      end
      rdata_o[DataWidth*p +: DataWidth] = rval;
    end
  end

endmodule
